// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR interface: word RAM plus one
// memory-mapped I/O word (switches in, hex display out), with fixed wait states.
module slc3_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_OE,
    input  logic        MEM_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic [15:0] SW,
    output logic [15:0] Data_to_CPU,
    output logic        R,
    output logic        BUSY,
    output logic [15:0] HEX_Data
);

    localparam logic [15:0] IO_ADDR   = 16'hFFFF;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        req, accept, commit;

    logic [15:0] lat_addr, lat_data;
    logic        lat_wr;
    logic [15:0] cur_addr, cur_data;
    logic        cur_wr, cur_io;
    logic [15:0] rd_word;

    logic [15:0] mem [2**ADDR_W];

    assign req = MEM_OE | MEM_WE;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_DONE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = S_DONE;
                    commit    = 1'b1;
                end
            end
            S_DONE:  state_nxt = req ? S_HOLD : S_IDLE;
            S_HOLD:  if (!req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accepting edge, so the
    // live request inputs stand in for the not-yet-latched copies.
    assign cur_addr = (state == S_IDLE) ? ADDR : lat_addr;
    assign cur_data = (state == S_IDLE) ? Data_from_CPU : lat_data;
    assign cur_wr   = (state == S_IDLE) ? (MEM_WE & ~MEM_OE) : lat_wr;
    assign cur_io   = (cur_addr == IO_ADDR);
    assign rd_word  = cur_io ? SW : mem[cur_addr[ADDR_W-1:0]];

    always_ff @(posedge Clk) begin
        if (accept) begin
            lat_addr <= ADDR;
            lat_data <= Data_from_CPU;
            lat_wr   <= MEM_WE & ~MEM_OE;
        end
    end

    // RAM is never reset; the Reset gate keeps a request held through reset
    // from writing when WAIT_CYCLES is zero.
    always_ff @(posedge Clk) begin
        if (commit && !Reset && cur_wr && !cur_io)
            mem[cur_addr[ADDR_W-1:0]] <= cur_data;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Data_to_CPU <= 16'h0000;
            HEX_Data    <= 16'h0000;
        end else if (commit) begin
            if (!cur_wr)
                Data_to_CPU <= rd_word;
            else if (cur_io)
                HEX_Data <= cur_data;
        end
    end

    assign R    = (state == S_DONE);
    assign BUSY = (state != S_IDLE);

endmodule
